// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed scan controller for an NDIG-digit common-anode 7-segment display
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIV  = 100000,
  parameter int unsigned NDIG = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dig_en,
  output logic [3:0]  code,
  output logic [7:0]  an,
  output logic        frame,
  output logic        pending
);

  localparam logic [23:0] CNT_LAST = 24'(DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NDIG - 1);

  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] pend_q, pend_d;
  logic        pending_q, pending_d;
  logic [3:0]  code_q, code_d;
  logic [7:0]  an_q, an_d;
  logic        frame_q, frame_d;
  logic        tick, wrap, lz_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      code_q    <= '0;
      an_q      <= 8'hFF;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  // A load coinciding with the wrap bypasses pend so the newest word wins.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    wrap      = tick && (idx_q == IDX_LAST);
    cnt_d     = tick ? '0 : cnt_q + 24'd1;
    idx_d     = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 3'd1;
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load)           disp_d = data_in;
      else if (pending_q) disp_d = pend_q;
    end else if (load) begin
      pend_d    = data_in;
      pending_d = 1'b1;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [2:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(NDIG); i++)
      if (disp_q[4*i +: 4] != 4'h0) msd = 3'(i);
  end
  assign lz_ok = (idx_q <= msd);
`else
  assign lz_ok = 1'b1;
`endif

  always_comb begin
    code_d  = disp_q[{idx_q, 2'b00} +: 4];
    an_d    = 8'hFF;
    if (dig_en[idx_q] && lz_ok && (32'(idx_q) < NDIG)) an_d[idx_q] = 1'b0;
    frame_d = wrap;
  end

  assign code    = code_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule
